// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   DATA_BITS       : payload bits per frame
//   uart_rx_state_e : receiver FSM encoding (PARITY only exists when
//                     UART_RX_PARITY_EN is defined)
//   calc_div        : clock-enable divider, shared with the transmitter
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
    , ST_PARITY  = 3'd5
`endif
  } uart_rx_state_e;

  // Integer floor of CLK_FREQ/(BAUD*OVERSAMPLE). Clamped to 1 so a very
  // slow system clock degrades to "tick every cycle" instead of never ticking.
  function automatic int calc_div(input int clk_freq, input int baud,
                                  input int oversample);
    int d;
    d = clk_freq / (baud * oversample);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle between the RX pin and user logic.
//   rx        : raw serial line (idles high)
//   rx_data   : last correctly received byte
//   rx_valid  : one-clk strobe when rx_data updates
//   frame_err : one-clk strobe on bad stop (or parity) bit
//   busy      : high from start-bit acceptance until back in IDLE
//   state     : receiver FSM state, for observation only
// Handshake: there is no ready. rx_valid and frame_err are single-cycle
// strobes that are never high together; the consumer must capture rx_data
// in the cycle rx_valid is high.
// modport master : the receiver; modport slave : pin driver / consumer.
interface uart_rx_if;
  import uart_pkg::*;

  logic           rx;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           frame_err;
  logic           busy;
  uart_rx_state_e state;

  modport master (
    input  rx,
    output rx_data, rx_valid, frame_err, busy, state
  );

  modport slave (
    output rx,
    input  rx_data, rx_valid, frame_err, busy, state
  );
endinterface

// File: rtl/uart_rx_baud_tick.sv
// Oversampling clock-enable generator with a synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart the count at 0 (aligns phase to a start edge)
//   tick       : one-clk pulse when the count reaches DIV-1
module uart_rx_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      // Clear wins so no tick is emitted from the old phase.
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      tick  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx.sv
// 8-bit asynchronous serial receiver, LSB first, 16x oversampling.
// Default frame is 8N1; defining UART_RX_PARITY_EN makes it 8E1 with a
// PARITY state between DATA and STOP.
//   clk   : system clock (rising edge)
//   rst_n : async assert, sync release, active low
//   bus   : uart_rx_if.master (rx in; rx_data/rx_valid/frame_err/busy/state out)
// OVERSAMPLE must be even and >= 8.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_rx_if.master   bus
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BIW = $clog2(DATA_BITS);

  localparam logic [TCW-1:0] HALF_LAST = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] FULL_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [BIW-1:0] LAST_BIT  = BIW'(DATA_BITS - 1);

  // Two-flop synchronizer; resets to the idle line level.
  logic sync1_q, sync2_q;
  logic rx_s;

  uart_rx_state_e         state_q, state_d;
  logic [TCW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [BIW-1:0]         bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                   parity_ok_q, parity_ok_d;
`endif

  logic div_clear;
  logic tick;
  logic sample_half;   // mid start bit reached
  logic sample_full;   // one full bit period elapsed

  assign rx_s = sync2_q;

  uart_rx_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (div_clear),
    .tick  (tick)
  );

  assign sample_half = tick && (tick_cnt_q == HALF_LAST);
  assign sample_full = tick && (tick_cnt_q == FULL_LAST);

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    div_clear   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_ok_d = parity_ok_q;
`endif

    // Ticks advance the bit-period counter in every counting state; the
    // sample points below override it with a restart.
    if (tick && (state_q != ST_IDLE) && (state_q != ST_WAIT_IDLE))
      tick_cnt_d = tick_cnt_q + TCW'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          // Restart the divider so sampling is phased to this edge.
          div_clear  = 1'b1;
          tick_cnt_d = '0;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        if (sample_half) begin
          tick_cnt_d = '0;
          if (!rx_s) begin
            bit_idx_d = '0;
            state_d   = ST_DATA;
          end else begin
            // Line went back high before mid start bit: a glitch.
            state_d = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (sample_full) begin
          tick_cnt_d         = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + BIW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (sample_full) begin
          tick_cnt_d  = '0;
          // Even parity: data plus parity bit hold an even number of ones.
          parity_ok_d = ~(^{shift_q, rx_s});
          state_d     = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (sample_full) begin
          tick_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          if (rx_s && parity_ok_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = ST_IDLE;
          end else if (rx_s) begin
            // Bad parity but the line is idle again, so no need to wait.
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_IDLE;
          end
`else
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_IDLE;
          end
`endif
        end
      end

      ST_WAIT_IDLE: begin
        // A held-low line (break) must not be decoded as repeated 0x00.
        if (rx_s) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_ok_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= bus.rx;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_ok_q <= parity_ok_d;
`endif
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.state     = state_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8-bit asynchronous serial receiver (8N1, LSB first). It is the receive-side counterpart to the team's UART transmitter and button-triggered transmit path.
- Samples the raw `rx` pin with a 2-flop synchronizer and a 16x oversampling clock-enable. No second clock domain is created.
- Each good frame delivers one byte with a single-cycle valid strobe. Framing errors are flagged.
- Sits between the board RX pin and user logic (LEDs, echo-back to the transmitter).

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- OVERSAMPLE, 16, ticks per bit. Must be even and ≥ 8.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  raw serial line. Idles high.
- rx_data  output  8  last correctly received byte.
- rx_valid  output  1  one-clk pulse when rx_data is updated.
- frame_err  output  1  one-clk pulse on bad stop bit (or bad parity when the option is enabled).
- busy  output  1  high from start-bit acceptance until return to IDLE.

Behaviour:
- Reset (async assert, sync release): synchronizer flops = 1; state = IDLE; rx_data = 8'h00; rx_valid = 0; frame_err = 0; busy = 0; all counters = 0.
- Synchronizer: 2 flops with reset value 1. Every decision uses the second-stage output `rx_s`. This adds 2 clk of input latency.
- Tick: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer floor (651 for the defaults). The divider counts 0..DIV-1 and asserts `tick` for one clk at DIV-1. It is cleared to 0 on start-edge detection so sample phase aligns to the edge.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - busy = 0.
  - On rx_s == 0, clear the tick divider and tick counter, then go to START.
- START:
  - busy = 1.
  - After OVERSAMPLE/2 ticks (mid start bit), sample rx_s.
  - If 0: clear counters, bit index = 0, go to DATA.
  - If 1: glitch. Return to IDLE with no outputs pulsed.
- DATA:
  - Every OVERSAMPLE ticks, sample rx_s into shift register bit [bit index] (LSB first).
  - After bit index 7, go to STOP.
- STOP: after OVERSAMPLE ticks, sample rx_s.
  - If 1: rx_data <= shift register, rx_valid pulses for 1 clk, go to IDLE.
  - If 0: frame_err pulses for 1 clk, rx_data is unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stays here until rx_s == 1, then goes to IDLE. This prevents a break condition from being read as a stream of 0x00 frames.
- Latency: rx_valid asserts at mid stop bit, 9.5 bit periods + 2 clk + ≤1 tick after the start falling edge.
- rx_valid and frame_err are never high in the same cycle. There is no backpressure; the consumer must capture on the strobe.
- Reset asserted mid-frame: the frame is aborted immediately with no strobes. After release, the block waits in IDLE for the next falling edge.
- A start edge in the same cycle as the return to IDLE is caught on the next clk. Back-to-back frames with a single stop bit must be received without loss.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state is inserted between DATA and STOP, sampled one bit period after data bit 7.
  - Parity mismatch or bad stop bit gives a frame_err pulse with rx_data unchanged.
  - A parity mismatch with a good stop bit goes to IDLE, not WAIT_IDLE.
  - rx_valid asserts one bit period later than without parity.
- Undefined: 8N1 exactly as above. No parity logic is synthesized.

Decomposition:
- Package uart_pkg: FSM state encoding, DATA_BITS = 8, and a DIV-calculation function shared with the transmitter.
- Sub-module uart_rx_baud_tick: divider with clk, rst_n, a sync clear input, and a tick output. It has the same structure as the team's clock-enable generator, with a clear input added.

Test Plan:
- Good byte: send 0x55 at 9600 baud (bit = 10416 clk at defaults) → exactly one rx_valid pulse, rx_data = 0x55, frame_err never high, busy returns to 0.
- Glitch reject: rx low for 2000 clk then high → busy pulses, no rx_valid/frame_err, FSM back in IDLE. Then send 0xA3 → rx_data = 0xA3.
- Framing error: send 0x3C with stop bit = 0, held low for a further 3 bit periods → one frame_err pulse, rx_data keeps its previous value, busy stays high until rx returns high. Then send 0x81 → rx_data = 0x81.
- Back-to-back: send 0xA5 then 0x3C with no idle gap → two rx_valid pulses exactly 10 bit periods ±1 tick apart, data in order.
- Reset mid-frame: assert rst_n = 0 during data bit 4 of 0xFF → outputs go to reset values immediately. After release, send 0x12 → rx_data = 0x12, no spurious strobe.
- With UART_RX_PARITY_EN: send 0x07 with even parity bit 1 → rx_valid, rx_data = 0x07. Send 0x07 with parity bit 0 → frame_err, rx_data unchanged.
